// File: rtl/pdm_demod.sv
// Integrate-and-dump PDM decoder: counts ones over windows of 2^NBITS-1 enabled
// cycles and presents the count as an NBITS-wide level estimate.
module pdm_demod #(
  parameter int NBITS       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic [NBITS-1:0] phase
);

  localparam logic [NBITS-1:0] LAST = {{(NBITS-1){1'b1}}, 1'b0};  // MAX-1

  logic             bit_s;
  logic [NBITS-1:0] acc, cnt, bit_ext;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign bit_s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign bit_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign bit_ext = {{(NBITS-1){1'b0}}, bit_s};
  assign phase   = cnt;

  // acc cannot overflow: at most MAX-1 ones precede the closing cycle.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (sync) begin
      acc        <= '0;
      cnt        <= '0;
      dout_valid <= 1'b0;
    end else if (!en) begin
      dout_valid <= 1'b0;
    end else if (cnt == LAST) begin
      dout       <= acc + bit_ext;
      dout_valid <= 1'b1;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      acc        <= acc + bit_ext;
      cnt        <= cnt + 1'b1;
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_demod.sv
// Bench for pdm_demod: two NBITS=4 instances (0 and 2 sync stages) share inputs
// and are compared every edge against a window-counting reference model.
module tb_pdm_demod;
  localparam int NB  = 4;
  localparam int MAX = (1 << NB) - 1;

  logic          clk = 1'b0, aresetn = 1'b0, din = 1'b0, en = 1'b0, sync = 1'b0;
  logic [NB-1:0] dout0, dout2, phase0, phase2;
  logic          vld0, vld2;

  int checks = 0, errors = 0;

  // Reference state: din history since reset plus per-instance window tallies.
  int din_log[$];
  int rst_idx = 0;
  int m_ones[2], m_len[2], m_dout[2], m_vld[2];
  int lat[2] = '{0, 2};

  pdm_demod #(.NBITS(NB), .SYNC_STAGES(0)) u0 (
    .clk(clk), .aresetn(aresetn), .din(din), .en(en), .sync(sync),
    .dout(dout0), .dout_valid(vld0), .phase(phase0));
  pdm_demod #(.NBITS(NB), .SYNC_STAGES(2)) u2 (
    .clk(clk), .aresetn(aresetn), .din(din), .en(en), .sync(sync),
    .dout(dout2), .dout_valid(vld2), .phase(phase2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rst_idx = din_log.size();
    for (int i = 0; i < 2; i++) begin
      m_ones[i] = 0; m_len[i] = 0; m_dout[i] = 0; m_vld[i] = 0;
    end
  endtask

  function automatic int delayed_bit(input int i);
    int k = din_log.size() - 1 - lat[i];
    return (k >= rst_idx) ? din_log[k] : 0;
  endfunction

  task automatic compare_all();
    chk("dout0", {28'd0, dout0}, m_dout[0]);
    chk("vld0", {31'd0, vld0}, m_vld[0]);
    chk("phase0", {28'd0, phase0}, m_len[0]);
    chk("dout2", {28'd0, dout2}, m_dout[1]);
    chk("vld2", {31'd0, vld2}, m_vld[1]);
    chk("phase2", {28'd0, phase2}, m_len[1]);
  endtask

  // One clock edge: snapshot inputs, let the edge happen, advance model, compare.
  task automatic tick();
    int d = din, e = en, s = sync, r = aresetn;
    @(posedge clk);
    #1;
    if (r == 0) begin
      model_reset();
    end else begin
      din_log.push_back(d);
      for (int i = 0; i < 2; i++) begin
        int b = delayed_bit(i);
        m_vld[i] = 0;
        if (s != 0) begin
          m_ones[i] = 0; m_len[i] = 0;
        end else if (e != 0) begin
          if (m_len[i] == MAX - 1) begin
            m_dout[i] = m_ones[i] + b; m_vld[i] = 1; m_ones[i] = 0; m_len[i] = 0;
          end else begin
            m_ones[i] += b; m_len[i]++;
          end
        end
      end
    end
    compare_all();
  endtask

  // Asynchronous pulse between edges; outputs must clear before the next edge.
  task automatic reset_pulse();
    #2 aresetn = 1'b0;
    #1;
    chk("rst_dout", {28'd0, dout0}, 0);
    chk("rst_vld", {31'd0, vld0}, 0);
    chk("rst_phase", {28'd0, phase0}, 0);
    chk("rst_phase2", {28'd0, phase2}, 0);
    model_reset();
    #1 aresetn = 1'b1;
  endtask

  task automatic wait_vld0(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!vld0 && n < 80);
    if (!vld0) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n, mod_acc, dval, strobes0, strobes2;

    // Reset state
    #12;
    chk("init_dout", {28'd0, dout0}, 0);
    chk("init_vld", {31'd0, vld0}, 0);
    chk("init_phase", {28'd0, phase0}, 0);
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;

    // All ones: strobe every 15 cycles with dout=15
    din = 1'b1; en = 1'b1;
    wait_vld0("ones_first", n);
    chk("ones_first_len", n, MAX);
    chk("ones_first_dout", {28'd0, dout0}, MAX);
    wait_vld0("ones_second", n);
    chk("ones_period", n, MAX);
    chk("ones_dout", {28'd0, dout0}, MAX);

    // All zeros, then ones from phase 7
    din = 1'b0;
    wait_vld0("zeros_a", n);
    wait_vld0("zeros_b", n);
    chk("zeros_dout", {28'd0, dout0}, 0);
    while (phase0 != 4'd7) tick();
    din = 1'b1;
    wait_vld0("half", n);
    chk("half_dout", {28'd0, dout0}, 8);
    wait_vld0("full_after", n);
    chk("full_after_dout", {28'd0, dout0}, MAX);

    // en alternating: 30-cycle strobe period
    wait_vld0("en_align", n);
    for (int j = 0; j < 2; j++) begin
      n = 0;
      do begin
        en = ~en;
        tick();
        n++;
      end while (!vld0 && n < 80);
      chk("en_gap_period", n, 2 * MAX);
      chk("en_gap_dout", {28'd0, dout0}, MAX);
    end
    en = 1'b1;

    // sync mid-window, then sync coinciding with the window end
    while (phase0 != 4'd9) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    chk("sync_phase", {28'd0, phase0}, 0);
    wait_vld0("after_sync", n);
    chk("after_sync_len", n, MAX);
    chk("after_sync_dout", {28'd0, dout0}, MAX);
    din = 1'b0;
    while (phase0 != 4'd14) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    chk("sync_end_vld", {31'd0, vld0}, 0);
    chk("sync_end_dout", {28'd0, dout0}, MAX);

    // Async reset mid-window, then a full 15-cycle first window
    din = 1'b1;
    repeat (5) tick();
    reset_pulse();
    wait_vld0("post_rst", n);
    chk("post_rst_len", n, MAX);

    // Sigma-delta streams with D=5 and D=11
    foreach (lat[k]) begin end
    for (int t = 0; t < 2; t++) begin
      dval = (t == 0) ? 5 : 11;
      reset_pulse();
      mod_acc = 0; strobes0 = 0; strobes2 = 0;
      repeat (8 * MAX) begin
        mod_acc += dval;
        if (mod_acc >= MAX) begin din = 1'b1; mod_acc -= MAX; end
        else din = 1'b0;
        tick();
        if (vld0) begin
          strobes0++;
          if (strobes0 > 1) chk("sd_range0", {31'd0, (dout0 >= dval - 1) && (dout0 <= dval + 1)}, 1);
        end
        if (vld2) begin
          strobes2++;
          if (strobes2 > 1) chk("sd_range2", {31'd0, (dout2 >= dval - 1) && (dout2 <= dval + 1)}, 1);
        end
      end
    end

    // Randomized traffic against the model
    for (int t = 0; t < 1500; t++) begin
      din  = 1'($urandom_range(1));
      en   = ($urandom_range(9) != 0);
      sync = ($urandom_range(49) == 0);
      if ($urandom_range(299) == 0) reset_pulse();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
